clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 172 +++++++++++++++++
 tb/tb_clk_div_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//    Samples a divided clock (clk_in) as data in the clk domain. It measures the
//    rise-to-rise period and the high time of clk_in, checks each measurement
//    against EXP_PERIOD +/- TOL, and tracks lock. It also reports a stuck clk_in
//    once TIMEOUT cycles pass without a rise.
//
// Ports
//    clk        sole clock, rising edge
//    rst        synchronous active-high reset
//    clk_in     divided clock under test
//    locked     high while in LOCKED
//    meas_vld   one-cycle pulse when period_o/high_o update
//    period_o   last measured period (clk cycles)
//    high_o     last measured high time (clk cycles)
//    err_pulse  one-cycle pulse on a bad period while LOCKED
//    stuck      one-cycle pulse on timeout
//    err_cnt    saturating count of err_pulse events
//
// state     | meaning
// ST_IDLE   | waiting for the first rise; that rise only starts the counter
// ST_ACQ    | counting consecutive good periods toward lock
// ST_LOCKED | LOCK_CNT good periods seen; a bad one flags an error
// ST_ERROR  | bad period seen while locked; waits for a good one
module clk_div_monitor #(
   parameter int CNT_W      = 8,
   parameter int EXP_PERIOD = 5,
   parameter int TOL        = 1,
   parameter int LOCK_CNT   = 4,
   parameter int TIMEOUT    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   output logic             locked,
   output logic             meas_vld,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             err_pulse,
   output logic             stuck,
   output logic [7:0]       err_cnt
);
   localparam int GC_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(EXP_PERIOD - TOL);
   localparam logic [CNT_W-1:0] P_MAX  = CNT_W'(EXP_PERIOD + TOL);
   localparam logic [CNT_W-1:0] T_OUT  = CNT_W'(TIMEOUT);
   localparam logic [GC_W-1:0]  G_LOCK = GC_W'(LOCK_CNT);

   typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCKED, ST_ERROR} state_t;

   state_t           state, state_nxt;
   logic             s1, s2, s3;
   logic             rise, fall;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] hi_q;
   logic [GC_W-1:0]  good_cnt, good_nxt, good_inc;
   logic             good_meas;
   logic             meas_now, err_now, stuck_now;

   assign rise     = s2 & ~s3;
   assign fall     = ~s2 & s3;
   assign good_inc = good_cnt + GC_W'(1);
   assign locked   = (state == ST_LOCKED);

   // run_cnt holds the cycles elapsed since the last rise, so on the next rise
   // it equals the period, and on a fall it equals the high time.
   assign good_meas = (run_cnt >= P_MIN) && (run_cnt <= P_MAX) &&
                      (hi_q != '0) && (hi_q < run_cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         s3      <= 1'b0;
         run_cnt <= '0;
         hi_q    <= '0;
      end else begin
         s1 <= clk_in;
         s2 <= s1;
         s3 <= s2;
         if (rise)
            run_cnt <= CNT_W'(1);
         else if (run_cnt != '1)
            run_cnt <= run_cnt + CNT_W'(1);
         if (fall)
            hi_q <= run_cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      meas_now  = 1'b0;
      err_now   = 1'b0;
      stuck_now = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_nxt = ST_ACQ;
               good_nxt  = '0;
            end
         end
         ST_ACQ: begin
            if (rise) begin
               meas_now = 1'b1;
               if (good_meas) begin
                  good_nxt = good_inc;
                  if (good_inc == G_LOCK)
                     state_nxt = ST_LOCKED;
               end else begin
                  good_nxt = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (rise) begin
               meas_now = 1'b1;
               if (!good_meas) begin
                  state_nxt = ST_ERROR;
                  err_now   = 1'b1;
               end
            end
         end
         ST_ERROR: begin
            if (rise) begin
               meas_now = 1'b1;
               if (good_meas) begin
                  state_nxt = ST_ACQ;
                  good_nxt  = GC_W'(1);
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      // A rise on the timeout cycle is a legitimate (long) period, so it wins.
      if (state != ST_IDLE && !rise && run_cnt == T_OUT) begin
         state_nxt = ST_IDLE;
         good_nxt  = '0;
         stuck_now = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meas_vld  <= 1'b0;
         period_o  <= '0;
         high_o    <= '0;
         err_pulse <= 1'b0;
         stuck     <= 1'b0;
         err_cnt   <= '0;
      end else begin
         meas_vld  <= meas_now;
         err_pulse <= err_now;
         stuck     <= stuck_now;
         if (meas_now) begin
            period_o <= run_cnt;
            high_o   <= hi_q;
         end
         if (err_now && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;
   localparam int CNT_W      = 8;
   localparam int EXP_PERIOD = 5;
   localparam int TOL        = 1;
   localparam int LOCK_CNT   = 4;
   localparam int TIMEOUT    = 32;
   localparam int MAXC       = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             clk_in;
   logic             locked, meas_vld, err_pulse, stuck;
   logic [CNT_W-1:0] period_o, high_o;
   logic [7:0]       err_cnt;

   clk_div_monitor #(
      .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TOL(TOL),
      .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .clk_in(clk_in), .locked(locked),
      .meas_vld(meas_vld), .period_o(period_o), .high_o(high_o),
      .err_pulse(err_pulse), .stuck(stuck), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_ACQ, M_LOCKED, M_ERR} mode_t;
   typedef struct {
      int period;
      int high;
      int lck;
      int errcnt;
   } ev_t;

   ev_t   log_q[$];
   int    n_stuck = 0;
   bit    started = 0;

   int    e_locked, e_meas, e_period, e_high, e_err, e_stuck, e_errcnt;
   int    seen[$];     // clk_in as sampled on recent edges, newest first
   int    rc, hq, streak;
   mode_t mode;

   initial begin
      int  s_prev2, s_prev3;
      bit  rise, fall, good;
      seen = '{0, 0, 0};
      rc = 0; hq = 0; streak = 0; mode = M_IDLE;
      e_locked = 0; e_meas = 0; e_period = 0; e_high = 0;
      e_err = 0; e_stuck = 0; e_errcnt = 0;
      forever begin
         @(posedge clk);
         e_meas = 0; e_err = 0; e_stuck = 0;
         if (rst) begin
            seen = '{0, 0, 0};
            rc = 0; hq = 0; streak = 0; mode = M_IDLE;
            e_period = 0; e_high = 0; e_errcnt = 0;
         end else begin
            // the design sees clk_in through a three-flop synchronizer
            s_prev2 = seen[1];
            s_prev3 = seen[2];
            rise = (s_prev2 == 1) && (s_prev3 == 0);
            fall = (s_prev2 == 0) && (s_prev3 == 1);
            if (rise) begin
               if (mode == M_IDLE) begin
                  mode = M_ACQ;
                  streak = 0;
               end else begin
                  e_meas = 1; e_period = rc; e_high = hq;
                  good = (rc >= EXP_PERIOD - TOL) && (rc <= EXP_PERIOD + TOL) &&
                         (hq > 0) && (hq < rc);
                  case (mode)
                     M_ACQ: begin
                        if (good) begin
                           streak++;
                           if (streak >= LOCK_CNT) mode = M_LOCKED;
                        end else streak = 0;
                     end
                     M_LOCKED: begin
                        if (!good) begin
                           mode = M_ERR; e_err = 1;
                           if (e_errcnt < 255) e_errcnt++;
                        end
                     end
                     M_ERR: begin
                        if (good) begin mode = M_ACQ; streak = 1; end
                     end
                     default: ;
                  endcase
               end
            end else if (mode != M_IDLE && rc == TIMEOUT) begin
               mode = M_IDLE; streak = 0; e_stuck = 1;
            end
            if (fall) hq = rc;
            rc = rise ? 1 : ((rc >= MAXC) ? MAXC : rc + 1);
            seen.push_front(int'(clk_in));
            void'(seen.pop_back());
         end
         e_locked = (mode == M_LOCKED) ? 1 : 0;
         if (e_meas) log_q.push_back('{e_period, e_high, e_locked, e_errcnt});
         if (e_stuck) n_stuck++;
         started = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("locked",    locked,    e_locked);
            chk("meas_vld",  meas_vld,  e_meas);
            chk("period_o",  period_o,  e_period);
            chk("high_o",    high_o,    e_high);
            chk("err_pulse", err_pulse, e_err);
            chk("stuck",     stuck,     e_stuck);
            chk("err_cnt",   err_cnt,   e_errcnt);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic per(input int hi, input int lo);
      clk_in = 1'b1; cyc(hi);
      clk_in = 1'b0; cyc(lo);
   endtask

   function automatic ev_t ev(input int i);
      ev_t z = '{0, 0, 0, 0};
      if (i >= 0 && i < log_q.size()) return log_q[i];
      return z;
   endfunction

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_locked"},   locked,    0);
      chk({tag, "_meas_vld"}, meas_vld,  0);
      chk({tag, "_period"},   period_o,  0);
      chk({tag, "_high"},     high_o,    0);
      chk({tag, "_err"},      err_pulse, 0);
      chk({tag, "_stuck"},    stuck,     0);
      chk({tag, "_err_cnt"},  err_cnt,   0);
   endtask

   initial begin
      int b, s, hi, lo;
      rst = 1'b1; clk_in = 1'b0;
      cyc(3);
      rst = 1'b0;
      #1 chk_outs_zero("reset");

      // div-by-5, high 3 / low 2
      repeat (6) per(3, 2);
      #1;
      chk("a_nmeas", log_q.size(), 5);
      chk("a_first_period", ev(0).period, 5);
      chk("a_first_high", ev(0).high, 3);
      chk("a_third_unlocked", ev(2).lck, 0);
      chk("a_fourth_locked", ev(3).lck, 1);
      chk("a_dut_locked", locked, 1);

      // one period stretched to 8
      b = log_q.size();
      per(3, 5);
      repeat (5) per(3, 2);
      #1;
      chk("b_nmeas", log_q.size(), b + 6);
      chk("b_long_period", ev(b + 1).period, 8);
      chk("b_long_errcnt", ev(b + 1).errcnt, 1);
      chk("b_long_unlocked", ev(b + 1).lck, 0);
      chk("b_acq3_unlocked", ev(b + 4).lck, 0);
      chk("b_relocked", ev(b + 5).lck, 1);
      chk("b_dut_errcnt", err_cnt, 1);

      // clk_in stuck low
      s = n_stuck;
      clk_in = 1'b0; cyc(40);
      #1;
      chk("c_stuck_once", n_stuck, s + 1);
      chk("c_dut_unlocked", locked, 0);
      b = log_q.size();
      repeat (5) per(3, 2);
      #1;
      chk("c_nmeas", log_q.size(), b + 4);
      chk("c_third_unlocked", ev(b + 2).lck, 0);
      chk("c_fourth_locked", ev(b + 3).lck, 1);

      // alternating 4 and 6, then a 7
      rst = 1'b1; cyc(2); rst = 1'b0;
      b = log_q.size();
      per(2, 2); per(3, 3); per(2, 2); per(3, 3); per(2, 2);
      per(3, 4); per(2, 2);
      #1;
      chk("d_nmeas", log_q.size(), b + 6);
      chk("d_p4", ev(b).period, 4);
      chk("d_h2", ev(b).high, 2);
      chk("d_p6", ev(b + 1).period, 6);
      chk("d_h3", ev(b + 1).high, 3);
      chk("d_third_unlocked", ev(b + 2).lck, 0);
      chk("d_fourth_locked", ev(b + 3).lck, 1);
      chk("d_p7", ev(b + 5).period, 7);
      chk("d_p7_unlocked", ev(b + 5).lck, 0);
      chk("d_p7_errcnt", ev(b + 5).errcnt, 1);

      // build err_cnt up to 3 while ending locked, then reset
      repeat (5) per(3, 2);
      repeat (2) begin
         per(3, 5);
         repeat (5) per(3, 2);
      end
      #1;
      chk("r_model_errcnt", e_errcnt, 3);
      chk("r_dut_errcnt", err_cnt, 3);
      chk("r_dut_locked", locked, 1);
      rst = 1'b1; cyc(1);
      #1 chk_outs_zero("midrst");
      rst = 1'b0;

      // rise exactly at the timeout count
      repeat (5) per(3, 2);
      s = n_stuck;
      b = log_q.size();
      per(3, 29); per(3, 2);
      #1;
      chk("e_no_stuck", n_stuck, s);
      chk("e_nmeas", log_q.size(), b + 2);
      chk("e_p5", ev(b).period, 5);
      chk("e_p32", ev(b + 1).period, 32);
      chk("e_h3", ev(b + 1).high, 3);
      per(3, 30); per(3, 2);
      #1;
      chk("e_stuck_33", n_stuck, s + 1);
      chk("e_nmeas_after", log_q.size(), b + 3);

      // randomized traffic with occasional long gaps and resets
      repeat (300) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1; cyc($urandom_range(1, 3)); rst = 1'b0;
         end
         hi = $urandom_range(1, 4);
         lo = ($urandom_range(0, 19) == 0) ? $urandom_range(25, 40) : $urandom_range(1, 5);
         per(hi, lo);
      end
      cyc(5);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
